data_mem_responder: RTL
=======================

Name: data_mem_responder

Overview:
- Data-memory slave for the multi-cycle MIPS core: the responder end of the mem_read_flag/mem_write_flag interface driven by the control unit.
- Latches one word access per request and inserts a configurable number of wait states.
- Signals completion with a one-cycle mem_ready pulse.
- Blocks re-triggering until the control unit drops its request flags, because those flags stay high across EX and MEM.

Parameters:
- DEPTH_LOG2, 8: log2 of word count; 256 x 32-bit words.
- WAIT_CYCLES, 2: wait-state cycles between accept and completion. Legal range 0..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- mem_read_flag  in  1  read request from control unit; level, held until mem_ready seen.
- mem_write_flag  in  1  write request from control unit; level, held until mem_ready seen.
- addr  in  32  byte address, from the ALU result.
- wdata  in  32  store data, from rt.
- rdata  out  32  load data; valid from the mem_ready cycle; held until the next read completes.
- mem_ready  out  1  one-cycle completion pulse.
- addr_err  out  1  one-cycle error pulse; the access is not performed.

Behaviour:
- Reset (rst=0), asynchronous:
  - state=IDLE, counter=0, rdata=0, mem_ready=0, addr_err=0, latched request cleared.
  - Memory array is not cleared.
  - A reset during BUSY aborts the access; no write is committed.
- States: IDLE, BUSY, DONE, HOLD.
- IDLE:
  - A request is present when mem_read_flag | mem_write_flag.
  - On a request, check the address:
    - Error if addr[1:0]!=0, or if addr[31:DEPTH_LOG2+2]!=0, or if both flags are high.
    - On error: addr_err=1 next cycle, go to HOLD, no memory access.
  - On a valid request:
    - Latch addr[DEPTH_LOG2+1:2], wdata and is_write=mem_write_flag.
    - Load counter=WAIT_CYCLES.
    - Go to BUSY, or straight to DONE when WAIT_CYCLES=0.
- BUSY:
  - Counter decrements each cycle; go to DONE when it reaches 0.
  - Input changes are ignored, including flags dropping early; the access still completes.
- DONE (exactly one cycle):
  - mem_ready=1.
  - Read: rdata=mem[latched index], registered so it is visible in this same cycle.
  - Write: mem[index]<=latched wdata at the clock edge ending DONE.
  - Next state is HOLD.
- HOLD:
  - mem_ready=0, addr_err=0.
  - Stay until both flags are low, then go to IDLE.
  - This prevents a second access from a still-asserted flag.
- Latency: accept edge + WAIT_CYCLES + 1, so mem_ready appears WAIT_CYCLES+1 cycles after the first request cycle.
  - WAIT_CYCLES=2: request sampled at edge 0; mem_ready high in cycle 3.
- Write commit timing: a read issued to the same word after a write completes returns the new data.
- Counter width: 4 bits.
- Outputs are registered; no combinational path from inputs to mem_ready, addr_err or rdata.
- mem_ready and addr_err are never high in the same cycle.

Test Plan:
1. Reset, then write: rst low then high; write addr=0x10, wdata=0xDEADBEEF, hold flag.
   - mem_ready pulses once, 3 cycles after the request.
   - State stays in HOLD until the flag drops.
   - A later read of 0x10 returns rdata=0xDEADBEEF on its mem_ready cycle.
2. Held flag: keep mem_read_flag high 10 cycles at addr=0x10.
   - Exactly one mem_ready pulse.
   - rdata stays at 0xDEADBEEF after the pulse.
3. Errors:
   - Read at addr=0x13: addr_err pulse 1 cycle after the request, no mem_ready.
   - Read at addr=0x400 (DEPTH_LOG2=8): addr_err.
   - Both flags high: addr_err, memory unchanged.
4. Abort: start a write of 0x12345678 to addr=0x20; assert rst during BUSY.
   - All outputs go to 0 immediately.
   - A read of 0x20 afterwards returns the old contents.
5. WAIT_CYCLES=0 build: read request.
   - mem_ready in the cycle right after the request is sampled.
   - Back-to-back write then read to addr=0x4 with a 1-cycle flag gap: the read returns the written value.
6. Early flag drop: drop mem_write_flag during BUSY.
   - The write still commits at DONE.
   - The FSM goes HOLD, then IDLE on the next cycle.

Source files
------------

// File: rtl/data_mem_responder_if.sv
// Request/response bundle between the control unit (master) and the
// data-memory responder (slave).
interface data_mem_responder_if;
  logic        mem_read_flag;
  logic        mem_write_flag;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        mem_ready;
  logic        addr_err;

  modport master (
    output mem_read_flag, mem_write_flag, addr, wdata,
    input  rdata, mem_ready, addr_err
  );

  modport slave (
    input  mem_read_flag, mem_write_flag, addr, wdata,
    output rdata, mem_ready, addr_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory slave for the multi-cycle MIPS core. Accepts one word access
// per request, waits WAIT_CYCLES cycles, pulses mem_ready for one cycle and
// then waits for the control unit to drop its level-held request flags.
module data_mem_responder #(
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  data_mem_responder_if.slave bus
);

  localparam int         DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, BUSY, DONE, HOLD} state_t;

  state_t                state, state_next;
  logic [3:0]            count, count_next;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic [31:0]           wdata_q;
  logic                  is_write_q;
  logic                  ready_q, err_q;
  logic [31:0]           rdata_q;
  logic [31:0]           mem [DEPTH];

  logic                  request, bad_addr, accept;
  logic                  ready_next, err_next, load_rdata;
  logic [DEPTH_LOG2-1:0] req_idx, rd_idx;

  assign request  = bus.mem_read_flag | bus.mem_write_flag;
  assign req_idx  = bus.addr[DEPTH_LOG2+1:2];
  assign bad_addr = (bus.addr[1:0] != 2'b00)
                 || ((bus.addr >> (DEPTH_LOG2 + 2)) != 32'd0)
                 || (bus.mem_read_flag && bus.mem_write_flag);

  // State and wait counter; reset drops any in-flight access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      count <= 4'd0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  // Next state plus the pulses and loads that happen on entering DONE/HOLD.
  always_comb begin
    state_next = state;
    count_next = count;
    accept     = 1'b0;
    ready_next = 1'b0;
    err_next   = 1'b0;
    load_rdata = 1'b0;
    rd_idx     = idx_q;
    case (state)
      IDLE: begin
        if (request) begin
          if (bad_addr) begin
            err_next   = 1'b1;
            state_next = HOLD;
          end else begin
            accept     = 1'b1;
            count_next = WAIT_LOAD;
            if (WAIT_CYCLES == 0) begin
              state_next = DONE;
              ready_next = 1'b1;
              load_rdata = !bus.mem_write_flag;
              rd_idx     = req_idx;
            end else begin
              state_next = BUSY;
            end
          end
        end
      end
      BUSY: begin
        count_next = count - 4'd1;
        if (count == 4'd1) begin
          state_next = DONE;
          ready_next = 1'b1;
          load_rdata = !is_write_q;
        end
      end
      DONE: begin
        state_next = HOLD;
      end
      HOLD: begin
        if (!request) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Latched request and registered outputs; rdata holds until the next read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q      <= '0;
      wdata_q    <= 32'd0;
      is_write_q <= 1'b0;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= 32'd0;
    end else begin
      ready_q <= ready_next;
      err_q   <= err_next;
      if (accept) begin
        idx_q      <= req_idx;
        wdata_q    <= bus.wdata;
        is_write_q <= bus.mem_write_flag;
      end
      if (load_rdata) begin
        rdata_q <= mem[rd_idx];
      end
    end
  end

  // Store commits on the edge that ends DONE; the array is never cleared.
  always_ff @(posedge clk) begin
    if (state == DONE && is_write_q) begin
      mem[idx_q] <= wdata_q;
    end
  end

  assign bus.rdata     = rdata_q;
  assign bus.mem_ready = ready_q;
  assign bus.addr_err  = err_q;

endmodule
